// File: rtl/cva6_boot_ctrl_pkg.sv
// Shared types and register map for the CVA6 boot/reset sequencer.
package cva6_boot_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_HOLD = 3'd0,
      SELECT     = 3'd1,
      DBG_REQ    = 3'd2,
      RUN        = 3'd3
   } boot_state_e;

   localparam logic [3:0] BOOT_LO = 4'h0;
   localparam logic [3:0] BOOT_HI = 4'h4;
   localparam logic [3:0] CTRL    = 4'h8;
   localparam logic [3:0] STATUS  = 4'hC;

   localparam int SOFT_RST = 0;
   localparam int ERR_CLR  = 1;

   // Boot ROM base of the surrounding SoC.
   localparam logic [63:0] DEF_BOOT_ADDR = 64'h0000_0000_1A00_0000;

endpackage

// File: rtl/cva6_boot_ctrl.sv
// Holds CVA6 in reset, presents its boot address and, for JTAG boot, requests debug
// until the core parks; includes a small register port for address, control and status.
import cva6_boot_ctrl_pkg::*;

module cva6_boot_ctrl #(
   parameter int          RstHoldCycles = 16,
   parameter int          DbgTimeout    = 1024,
   parameter logic [63:0] DefBootAddr   = DEF_BOOT_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        boot_sel_i,
   input  logic        dm_halted_i,
   output logic        core_rst_o,
   output logic [63:0] boot_addr_o,
   output logic        debug_req_o,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
   localparam int DbgW  = (DbgTimeout > 1) ? $clog2(DbgTimeout) : 1;

   localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 1);
   localparam logic [DbgW-1:0]  DbgLast  = DbgW'(DbgTimeout - 1);

   boot_state_e      state;
   logic [HoldW-1:0] hold_cnt;
   logic [DbgW-1:0]  dbg_cnt;

   logic [3:0]  reg_addr;
   logic        wr_en;
   logic        soft_rst;
   logic        err_clr;
   logic [31:0] read_data;
   logic        unused_addr;

   assign reg_addr    = {addr_i[3:2], 2'b00};
   assign unused_addr = ^addr_i[1:0];
   assign wr_en       = req_i && we_i;
   assign soft_rst    = wr_en && (reg_addr == CTRL) && wdata_i[SOFT_RST];
   assign err_clr     = wr_en && (reg_addr == CTRL) && wdata_i[ERR_CLR];

   always_comb begin
      read_data = '0;
      case (reg_addr)
         BOOT_LO: read_data = boot_addr_o[31:0];
         BOOT_HI: read_data = boot_addr_o[63:32];
         STATUS:  read_data = {27'b0, err_o, state};
         default: read_data = '0;
      endcase
   end

   // Everything below decides on pre-edge state, so a register write racing a
   // state change sees the old state (e.g. boot address locked until core_rst_o rises).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RESET_HOLD;
         hold_cnt    <= '0;
         dbg_cnt     <= '0;
         core_rst_o  <= 1'b1;
         boot_addr_o <= DefBootAddr;
         debug_req_o <= 1'b0;
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         rdata_o  <= (req_i && !we_i) ? read_data : 32'h0;

         if (wr_en && core_rst_o && (reg_addr == BOOT_LO)) boot_addr_o[31:0]  <= wdata_i;
         if (wr_en && core_rst_o && (reg_addr == BOOT_HI)) boot_addr_o[63:32] <= wdata_i;

         if (soft_rst) begin
            state       <= RESET_HOLD;
            hold_cnt    <= '0;
            dbg_cnt     <= '0;
            core_rst_o  <= 1'b1;
            debug_req_o <= 1'b0;
         end else begin
            case (state)
               RESET_HOLD: begin
                  core_rst_o <= 1'b1;
                  if (hold_cnt == HoldLast) begin
                     hold_cnt <= '0;
                     state    <= SELECT;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               SELECT: begin
                  core_rst_o <= 1'b0;
                  dbg_cnt    <= '0;
                  if (boot_sel_i) begin
                     state       <= DBG_REQ;
                     debug_req_o <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
               DBG_REQ: begin
                  if (dm_halted_i) begin
                     state       <= RUN;
                     debug_req_o <= 1'b0;
                     dbg_cnt     <= '0;
                  end else if (dbg_cnt == DbgLast) begin
                     state       <= RUN;
                     debug_req_o <= 1'b0;
                     dbg_cnt     <= '0;
                     err_o       <= 1'b1;
                  end else begin
                     dbg_cnt <= dbg_cnt + 1'b1;
                  end
               end
               RUN: begin
                  core_rst_o  <= 1'b0;
                  debug_req_o <= 1'b0;
               end
               default: begin
                  state      <= RESET_HOLD;
                  hold_cnt   <= '0;
                  core_rst_o <= 1'b1;
               end
            endcase
         end

         if (err_clr) err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cva6_boot_ctrl.sv
// Directed self-checking bench for cva6_boot_ctrl: a register-access vector table plus
// hand-written boot sequences (ROM, JTAG, timeout, address lock, soft and hard reset).
import cva6_boot_ctrl_pkg::*;

module tb_cva6_boot_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        boot_sel_i;
   logic        dm_halted_i;
   logic        core_rst_o;
   logic [63:0] boot_addr_o;
   logic        debug_req_o;
   logic        req_i;
   logic        we_i;
   logic [3:0]  addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[11];

   localparam logic [63:0] DefAddr = DEF_BOOT_ADDR;

   cva6_boot_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .boot_sel_i  (boot_sel_i),
      .dm_halted_i (dm_halted_i),
      .core_rst_o  (core_rst_o),
      .boot_addr_o (boot_addr_o),
      .debug_req_o (debug_req_o),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic reg_access(input logic we, input logic [3:0] addr, input logic [31:0] wdata);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = addr;
      wdata_i = wdata;
      tick();
      req_i   = 1'b0;
      we_i    = 1'b0;
   endtask

   task automatic wait_release(output int n);
      n = 0;
      while (core_rst_o && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_debug_req(output int n);
      n = 0;
      while (!debug_req_o && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int hi;
      bit seen_dbg;

      vecs[0]  = '{1'b1, 1'b0, BOOT_LO, 32'h0,          1'b1, DefAddr[31:0]};
      vecs[1]  = '{1'b1, 1'b0, BOOT_HI, 32'h0,          1'b1, DefAddr[63:32]};
      vecs[2]  = '{1'b1, 1'b0, CTRL,    32'h0,          1'b1, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, STATUS,  32'h0,          1'b1, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, BOOT_LO, 32'h1234_5678,  1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, BOOT_LO, 32'h0,          1'b1, 32'h1234_5678};
      vecs[6]  = '{1'b1, 1'b1, BOOT_HI, 32'hA5A5_0000,  1'b1, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, BOOT_HI, 32'h0,          1'b1, 32'hA5A5_0000};
      vecs[8]  = '{1'b0, 1'b0, BOOT_LO, 32'h0,          1'b0, 32'h0};
      vecs[9]  = '{1'b1, 1'b1, BOOT_LO, DefAddr[31:0],  1'b1, 32'h0};
      vecs[10] = '{1'b1, 1'b1, BOOT_HI, DefAddr[63:32], 1'b1, 32'h0};

      rst_i = 1'b1; boot_sel_i = 1'b0; dm_halted_i = 1'b0;
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;

      // Reset values
      do_reset();
      check("rst_core_rst", core_rst_o, 1);
      check("rst_boot_addr", boot_addr_o, DefAddr);
      check("rst_debug_req", debug_req_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_err", err_o, 0);

      // Register table, all inside the reset hold window
      for (int i = 0; i < 11; i++) begin
         req_i = vecs[i].req; we_i = vecs[i].we;
         addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
         tick();
         check($sformatf("vec%0d_rvalid", i), rvalid_o, vecs[i].exp_rvalid);
         check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
         check($sformatf("vec%0d_core_rst", i), core_rst_o, 1);
      end
      req_i = 1'b0; we_i = 1'b0;

      // ROM boot
      do_reset();
      boot_sel_i = 1'b0;
      n = 0; seen_dbg = 0;
      while (core_rst_o && n < 200) begin
         tick();
         n++;
         if (debug_req_o) seen_dbg = 1;
      end
      check("rom_release_cycles", n, 17);
      check("rom_boot_addr", boot_addr_o, DefAddr);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (debug_req_o) seen_dbg = 1;
      end
      check("rom_no_debug_req", seen_dbg, 0);
      reg_access(1'b0, STATUS, 32'h0);
      check("rom_status", rdata_o, 32'h3);

      // JTAG boot, core halts in the fifth DBG_REQ cycle
      do_reset();
      boot_sel_i = 1'b1;
      wait_debug_req(n);
      check("jtag_dbg_start", n, 17);
      check("jtag_core_rst", core_rst_o, 0);
      hi = 0;
      while (debug_req_o && hi < 20) begin
         hi++;
         if (hi == 5) dm_halted_i = 1'b1;
         tick();
      end
      dm_halted_i = 1'b0;
      check("jtag_dbg_cycles", hi, 5);
      reg_access(1'b0, STATUS, 32'h0);
      check("jtag_status", rdata_o, 32'h3);
      check("jtag_err", err_o, 0);

      // Debug halt timeout
      do_reset();
      boot_sel_i = 1'b1;
      wait_debug_req(n);
      hi = 0;
      while (debug_req_o && hi < 2000) begin
         hi++;
         tick();
      end
      check("tmo_dbg_cycles", hi, 1024);
      check("tmo_err", err_o, 1);
      reg_access(1'b0, STATUS, 32'h0);
      check("tmo_status", rdata_o, 32'hB);
      reg_access(1'b1, CTRL, 32'h2);
      check("tmo_err_clr", err_o, 0);
      check("tmo_clr_no_softrst", core_rst_o, 0);

      // Boot address locked while running, writable after soft reset
      reg_access(1'b1, BOOT_LO, 32'hDEAD_BEEF);
      check("lock_wr_rvalid", rvalid_o, 1);
      reg_access(1'b0, BOOT_LO, 32'h0);
      check("lock_readback", rdata_o, DefAddr[31:0]);
      reg_access(1'b1, CTRL, 32'h1);
      check("soft_core_rst", core_rst_o, 1);
      reg_access(1'b1, BOOT_HI, 32'h1);
      reg_access(1'b1, BOOT_LO, 32'h8000_0000);
      boot_sel_i = 1'b0;
      wait_release(n);
      check("newaddr_release", core_rst_o, 0);
      check("newaddr_boot_addr", boot_addr_o, 64'h0000_0001_8000_0000);

      // Hard reset with a read response in flight
      req_i = 1'b1; we_i = 1'b0; addr_i = STATUS;
      tick();
      check("inflight_rvalid", rvalid_o, 1);
      req_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("hrst_rvalid", rvalid_o, 0);
      check("hrst_rdata", rdata_o, 0);
      check("hrst_core_rst", core_rst_o, 1);
      check("hrst_boot_addr", boot_addr_o, DefAddr);
      check("hrst_debug_req", debug_req_o, 0);

      // Soft reset in the third DBG_REQ cycle replays the full hold
      do_reset();
      boot_sel_i = 1'b1;
      wait_debug_req(n);
      tick();
      tick();
      check("sr_dbg_before", debug_req_o, 1);
      reg_access(1'b1, CTRL, 32'h1);
      check("sr_debug_req", debug_req_o, 0);
      check("sr_core_rst", core_rst_o, 1);
      boot_sel_i = 1'b0;
      wait_release(n);
      check("sr_release_cycles", n, 17);
      check("sr_debug_after", debug_req_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
